adc_sequencer: RTL and testbench
================================

Name: adc_sequencer

Overview:
- Digital control stage directly upstream and downstream of the adc block.
- Generates the seq_init / seq_samp / seq_comp / seq_update phase signals that drive adc's clock gate.
- Samples adc's serial comp_out once per comparison cycle and assembles the Madc raw decisions into one word.
- Presents each word on a single-entry valid/ready output buffer for the readout chain.

Parameters:
- Madc, 17, number of comparison cycles per conversion; must match adc's Madc; also the raw word width.
- SAMP_W, 4, width of the samp_len input.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request for one conversion; ignored unless the FSM is in IDLE.
- cont  in  1  continuous mode: while high, IDLE automatically starts a new conversion.
- samp_len  in  SAMP_W  number of cycles in the SAMP phase; 0 is treated as 1.
- comp_out  in  1  comparator decision from adc.
- seq_init  out  1  init phase to adc.
- seq_samp  out  1  sampling phase to adc.
- seq_comp  out  1  comparator phase to adc.
- seq_update  out  1  SAR update phase to adc.
- busy  out  1  high in every state except IDLE.
- res_data  out  Madc  raw decisions; MSB is the first comparison.
- res_valid  out  1  result buffer full.
- res_ready  in  1  consumer accepts res_data when res_valid and res_ready are both high.
- overrun  out  1  sticky flag: a completed conversion was dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset values: all seq_* = 0, busy = 0, res_valid = 0, res_data = 0, overrun = 0, FSM = IDLE. Reset mid-conversion aborts immediately; the partial word is discarded.
- All seq_* outputs are registered, and exactly one (or none) is high in any cycle.
- FSM states and transitions:
  - IDLE -> INIT on (start | cont).
  - INIT: 1 cycle, seq_init = 1; -> SAMP.
  - SAMP: max(samp_len, 1) cycles, seq_samp = 1; samp_len is latched on entry to INIT; -> COMP.
  - COMP: 1 cycle, seq_comp = 1. comp_out is sampled on the cycle after seq_comp is asserted, i.e. the first cycle of the following state; the sample is shifted into the LSB of the shift register (left-shift).
  - After COMP, if bit_cnt < Madc-1: -> UPDATE; otherwise -> DONE.
  - UPDATE: 1 cycle, seq_update = 1; bit_cnt increments; -> COMP.
  - Each conversion therefore has Madc COMP phases and Madc-1 UPDATE phases.
  - DONE: 1 cycle. Captures the final comp_out sample and transfers the word to the buffer; -> IDLE.
- Latency: start accepted in cycle 0 -> res_valid rises in cycle 1 + samp + 2*Madc (with samp = max(samp_len, 1)). Example: samp_len = 4, Madc = 17 -> cycle 39.
- Output buffer rules:
  - Transfer when empty: res_valid <= 1 on the next edge.
  - Transfer when full and res_ready = 1 in the same cycle: the new word replaces the old one; res_valid stays 1.
  - Transfer when full and res_ready = 0: the new word is dropped and overrun <= 1.
  - Accept without transfer: res_valid <= 0.
- overrun is cleared only by ovr_clr or rst. If ovr_clr coincides with a new overrun event, set wins.
- start while busy is ignored, with no queueing. Deasserting cont mid-conversion finishes the current conversion, then the FSM stays in IDLE.
- bit_cnt has width $clog2(Madc) and wraps to 0 in INIT.

Optional Feature:
- Macro ADC_SEQ_CONV_CNT_EN.
- Defined: adds output conv_cnt [15:0], reset 0, incremented on every DONE (dropped conversions included), wrapping 0xFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package adc_seq_pkg holds:
  - state typedef: IDLE, INIT, SAMP, COMP, UPDATE, DONE;
  - localparam for the conv_cnt width (16).
- Madc stays a module parameter.
- One natural sub-module: adc_seq_outbuf, the single-entry valid/ready register with overrun detection.

Test Plan:
- Reset mid-SAMP: rst for 1 cycle -> next cycle all seq_* = 0, busy = 0, res_valid = 0; a following start produces a full, correct conversion.
- Single conversion, Madc = 17, samp_len = 4, comp_out pattern 1,0,1,... applied per COMP phase -> res_data = 17'h15555, res_valid at cycle 39, exactly 17 seq_comp and 16 seq_update pulses.
- samp_len = 0 -> seq_samp high for exactly 1 cycle.
- cont = 1, res_ready = 1 -> back-to-back conversions with a 1-cycle IDLE gap; every word is delivered; overrun stays 0.
- cont = 1, res_ready = 0 -> first word is held unchanged; second DONE sets overrun = 1. Asserting ovr_clr together with a third DONE -> overrun remains 1.
- start asserted while busy -> no effect. With ADC_SEQ_CONV_CNT_EN defined, 3 conversions -> conv_cnt = 3.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC sequencer: FSM state encoding and conversion counter width.
package adc_seq_pkg;
  typedef enum logic [2:0] {IDLE, INIT, SAMP, COMP, UPDATE, DONE} state_t;
  localparam int CONV_CNT_W = 16;
endpackage

// File: rtl/adc_seq_outbuf.sv
// Single-entry valid/ready result register with sticky overrun flag.
module adc_seq_outbuf #(
  parameter int Madc = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr,
  input  logic [Madc-1:0] i_data,
  input  logic            i_ready,
  input  logic            i_ovr_clr,
  output logic            o_valid,
  output logic [Madc-1:0] o_data,
  output logic            o_overrun
);
  logic            r_valid;
  logic [Madc-1:0] r_data;
  logic            r_overrun;
  logic            w_load;
  logic            w_drop;

  // A new word lands when the slot is empty or is being drained this same cycle.
  assign w_load = i_wr & (~r_valid | i_ready);
  assign w_drop = i_wr & r_valid & ~i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load)
        r_valid <= 1'b1;
      else if (r_valid & i_ready)
        r_valid <= 1'b0;
      if (w_load)
        r_data <= i_data;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (i_ovr_clr)
        r_overrun <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC phase sequencer and decision assembler.
// Optional conv_cnt output enabled by defining ADC_SEQ_CONV_CNT_EN.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int Madc   = 17,
  parameter int SAMP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [SAMP_W-1:0] samp_len,
  input  logic              comp_out,
  input  logic              res_ready,
  input  logic              ovr_clr,
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_comp,
  output logic              seq_update,
  output logic              busy,
  output logic [Madc-1:0]   res_data,
  output logic              res_valid,
`ifdef ADC_SEQ_CONV_CNT_EN
  output logic [CONV_CNT_W-1:0] conv_cnt,
`endif
  output logic              overrun
);
  localparam int BC_W = $clog2(Madc);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [SAMP_W-1:0] r_samp_len;
  logic [SAMP_W-1:0] r_samp_cnt;
  logic [Madc-2:0]   r_shift;
  logic              r_seq_init;
  logic              r_seq_samp;
  logic              r_seq_comp;
  logic              r_seq_update;
  logic              w_more_bits;
  logic              w_samp_end;
  logic              w_xfer;
  logic [Madc-1:0]   w_word;

  assign w_more_bits = (r_bit_cnt < BC_W'(Madc - 1));
  assign w_samp_end  = (r_samp_cnt == (r_samp_len - SAMP_W'(1)));
  assign w_xfer      = (r_state == DONE);
  // DONE cycle folds in the final decision directly; it never reaches r_shift.
  assign w_word      = {r_shift, comp_out};

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start | cont) w_state_nxt = INIT;
      INIT:    w_state_nxt = SAMP;
      SAMP:    if (w_samp_end) w_state_nxt = COMP;
      COMP:    w_state_nxt = w_more_bits ? UPDATE : DONE;
      UPDATE:  w_state_nxt = COMP;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Phase outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_init   <= 1'b0;
      r_seq_samp   <= 1'b0;
      r_seq_comp   <= 1'b0;
      r_seq_update <= 1'b0;
    end else begin
      r_seq_init   <= (w_state_nxt == INIT);
      r_seq_samp   <= (w_state_nxt == SAMP);
      r_seq_comp   <= (w_state_nxt == COMP);
      r_seq_update <= (w_state_nxt == UPDATE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_len <= SAMP_W'(1);
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if ((r_state == IDLE) && (w_state_nxt == INIT))
        r_samp_len <= (samp_len == '0) ? SAMP_W'(1) : samp_len;
      if (r_state == INIT)
        r_samp_cnt <= '0;
      else if (r_state == SAMP)
        r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
      if (r_state == INIT)
        r_bit_cnt <= '0;
      else if (r_state == UPDATE)
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
    end
  end

  // UPDATE is the cycle after a COMP, so comp_out holds that comparison's decision.
  always_ff @(posedge clk) begin
    if (r_state == INIT)
      r_shift <= '0;
    else if (r_state == UPDATE)
      r_shift <= {r_shift[Madc-3:0], comp_out};
  end

`ifdef ADC_SEQ_CONV_CNT_EN
  logic [CONV_CNT_W-1:0] r_conv_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_conv_cnt <= '0;
    else if (w_xfer)
      r_conv_cnt <= r_conv_cnt + CONV_CNT_W'(1);
  end

  assign conv_cnt = r_conv_cnt;
`endif

  adc_seq_outbuf #(.Madc(Madc)) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_xfer),
    .i_data    (w_word),
    .i_ready   (res_ready),
    .i_ovr_clr (ovr_clr),
    .o_valid   (res_valid),
    .o_data    (res_data),
    .o_overrun (overrun)
  );

  assign seq_init   = r_seq_init;
  assign seq_samp   = r_seq_samp;
  assign seq_comp   = r_seq_comp;
  assign seq_update = r_seq_update;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: table vectors, random conversions, multi-cycle corner sequences.
module tb_adc_sequencer;
  localparam int M  = 17;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          cont;
  logic [SW-1:0] samp_len;
  logic          comp_out;
  logic          res_ready;
  logic          ovr_clr;
  logic          seq_init;
  logic          seq_samp;
  logic          seq_comp;
  logic          seq_update;
  logic          busy;
  logic [M-1:0]  res_data;
  logic          res_valid;
  logic          overrun;
`ifdef ADC_SEQ_CONV_CNT_EN
  logic [15:0]   conv_cnt;
`endif

  adc_sequencer #(.Madc(M), .SAMP_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .samp_len   (samp_len),
    .comp_out   (comp_out),
    .res_ready  (res_ready),
    .ovr_clr    (ovr_clr),
    .seq_init   (seq_init),
    .seq_samp   (seq_samp),
    .seq_comp   (seq_comp),
    .seq_update (seq_update),
    .busy       (busy),
    .res_data   (res_data),
    .res_valid  (res_valid),
`ifdef ADC_SEQ_CONV_CNT_EN
    .conv_cnt   (conv_cnt),
`endif
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_init = 0, n_samp = 0, n_comp = 0, n_upd = 0, n_done = 0, onehot_err = 0;
  bit done_now;
  logic [M-1:0] cur_bits;
  logic [M-1:0] fixed_bits;
  bit           use_fixed;
  int           kbit;
  logic [M-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock, observe just after the edge and play the ADC's comparator.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if ($countones({seq_init, seq_samp, seq_comp, seq_update}) > 1) onehot_err++;
    done_now = busy && !(seq_init || seq_samp || seq_comp || seq_update);
    if (done_now) n_done++;
    if (seq_init) begin
      n_init++;
      cur_bits = use_fixed ? fixed_bits : M'($urandom);
      exp_q.push_back(cur_bits);
      kbit = 0;
    end
    if (seq_samp) n_samp++;
    if (seq_update) n_upd++;
    if (seq_comp) begin
      n_comp++;
      if (kbit < M) comp_out = cur_bits[M-1-kbit];
      kbit++;
    end
  endtask

  task automatic clr_counts();
    n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0;
  endtask

  task automatic run_conv(input logic [SW-1:0] sl, input logic [M-1:0] bits, input bit poke,
                          output logic [M-1:0] data, output int lat);
    samp_len = sl;
    fixed_bits = bits;
    use_fixed = 1'b1;
    clr_counts();
    start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n < 200; n++) begin
      if (poke && (n == 5 || n == 20)) start = 1'b1;
      step();
      start = 1'b0;
      if (res_valid) begin
        lat = n;
        break;
      end
    end
    data = res_data;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("drain_valid", res_valid, 0);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step();
    end
    chk(name, busy, 0);
  endtask

  typedef struct {
    logic [SW-1:0] samp_len;
    logic [M-1:0]  bits;
    logic [M-1:0]  exp_data;
    int            exp_lat;
    int            exp_samp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [M-1:0] got;
    int lat;
    int last_init;
    int d;

    tbl[0] = '{4'd4,  17'h15555, 17'h15555, 39, 4};
    tbl[1] = '{4'd0,  17'h1FFFF, 17'h1FFFF, 36, 1};
    tbl[2] = '{4'd1,  17'h00001, 17'h00001, 36, 1};
    tbl[3] = '{4'd15, 17'h10000, 17'h10000, 50, 15};
    tbl[4] = '{4'd7,  17'h0ABCD, 17'h0ABCD, 42, 7};

    rst = 1'b1; start = 1'b0; cont = 1'b0; samp_len = '0; comp_out = 1'b0;
    res_ready = 1'b0; ovr_clr = 1'b0; use_fixed = 1'b1; fixed_bits = '0; kbit = 0;
    step();
    chk("reset_seq", {seq_init, seq_samp, seq_comp, seq_update}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_data", res_data, 0);
    chk("reset_overrun", overrun, 0);
    step();
    rst = 1'b0;
    n_done = 0;
`ifdef ADC_SEQ_CONV_CNT_EN
    chk("reset_conv_cnt", conv_cnt, 0);
`endif

    // Reset in the middle of SAMP aborts the conversion.
    samp_len = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("midsamp_in_samp", seq_samp, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midsamp_rst_outs", {seq_init, seq_samp, seq_comp, seq_update, busy, res_valid}, 0);
    n_done = 0;
    run_conv(4'd3, 17'h1A5A5, 1'b0, got, lat);
    chk("post_rst_data", got, 17'h1A5A5);
    chk("post_rst_lat", lat, 38);

    for (int i = 0; i < 5; i++) begin
      run_conv(tbl[i].samp_len, tbl[i].bits, (i == 0), got, lat);
      chk($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_samp", i), n_samp, tbl[i].exp_samp);
      chk($sformatf("tbl%0d_comp", i), n_comp, 17);
      chk($sformatf("tbl%0d_upd", i), n_upd, 16);
      chk($sformatf("tbl%0d_init", i), n_init, 1);
`ifdef ADC_SEQ_CONV_CNT_EN
      if (i == 1) chk("conv_cnt_3", conv_cnt, 3);
`endif
    end

    // Random conversions against an arithmetic model of latency and word assembly.
    for (int r = 0; r < 8; r++) begin
      int s;
      bit b[$];
      logic [M-1:0] w;
      s = $urandom_range(0, 15);
      w = '0;
      for (int i = 0; i < M; i++) begin
        b.push_back(1'($urandom_range(0, 1)));
        w = {w[M-2:0], b[i]};
      end
      run_conv(SW'(s), w, 1'b0, got, lat);
      chk($sformatf("rnd%0d_data", r), got, w);
      chk($sformatf("rnd%0d_lat", r), lat, 1 + ((s == 0) ? 1 : s) + 2 * M);
      chk($sformatf("rnd%0d_comp", r), n_comp, M);
    end

    // Continuous mode with a ready consumer.
    exp_q.delete();
    use_fixed = 1'b0;
    samp_len = 4'd2;
    res_ready = 1'b1;
    cont = 1'b1;
    last_init = -1;
    for (int i = 0; i < 260; i++) begin
      if (i == 200) cont = 1'b0;
      step();
      if (seq_init) begin
        if (last_init >= 0) chk("cont_spacing", cyc - last_init, 38);
        last_init = cyc;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) chk("cont_unexpected_word", 1, 0);
        else chk("cont_word", res_data, exp_q.pop_front());
      end
      if (i > 200 && !busy && !res_valid) break;
    end
    chk("cont_all_delivered", exp_q.size(), 0);
    chk("cont_overrun", overrun, 0);
    chk("cont_idle", busy, 0);
    res_ready = 1'b0;

    // Continuous mode with a stalled consumer: hold first word, flag overrun, set beats clear.
    exp_q.delete();
    samp_len = 4'd1;
    cont = 1'b1;
    d = 0;
    for (int i = 0; i < 400 && d < 3; i++) begin
      step();
      if (done_now) begin
        d++;
        if (d == 3) begin
          ovr_clr = 1'b1;
          cont = 1'b0;
        end
        step();
        ovr_clr = 1'b0;
        chk($sformatf("ovr_hold%0d", d), res_data, exp_q[0]);
        chk($sformatf("ovr_valid%0d", d), res_valid, 1);
        chk($sformatf("ovr_flag%0d", d), overrun, (d >= 2) ? 1 : 0);
      end
    end
    chk("ovr_done_count", d, 3);
    wait_idle("ovr_idle");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_still_held", res_data, exp_q[0]);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ovr_drained", res_valid, 0);

    chk("seq_onehot_errs", onehot_err, 0);
`ifdef ADC_SEQ_CONV_CNT_EN
    chk("conv_cnt_total", conv_cnt, 32'(n_done[15:0]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
